pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MA/WB).

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_lu_cmp.sv | 19 +
 rtl/pipeline_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Optional perf counters in pipeline_ctrl are enabled by PIPELINE_CTRL_PERF_EN.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } ctrl_state_e;

    localparam logic [1:0]  WBSEL_MEM  = 2'd0;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    // A source operand hazards on rd only when the ID instruction actually reads it.
    function automatic logic src_hit(input logic used, input logic [4:0] rs,
                                     input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_lu_cmp.sv
// Combinational load-use detector: a load in EX whose rd feeds the ID instruction.
module pipeline_ctrl_lu_cmp
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwen,
    input  logic       ex_is_load,
    output logic       lu
);

    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    assign lu = ex_is_load && ex_regwen && (ex_rd != 5'd0) &&
                (src_hit(id_rs1_used, id_rs1, ex_rd) || src_hit(id_rs2_used, id_rs2, ex_rd));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, memory wait, debug drain.
// Define PIPELINE_CTRL_PERF_EN to build the saturating perf counters; otherwise perf_* read 0.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwen,
    input  logic             ex_is_load,
    input  logic             ex_pcsel,
    input  logic             ma_mem_req,
    input  logic             ma_mem_ready,
    input  logic             dbg_halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exma_en,
    output logic             mawb_bubble,
    output logic             halt_ack,
    output logic             mem_err,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] perf_lu,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_memwait
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    ctrl_state_e   state_q, state_d, ret_q, ret_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          abort_q, abort_d;
    logic          mem_err_q, mem_err_d;
    logic          lu;
    logic          memstall;

    pipeline_ctrl_lu_cmp u_lu_cmp (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_regwen   (ex_regwen),
        .ex_is_load  (ex_is_load),
        .lu          (lu)
    );

    assign memstall = ma_mem_req && !ma_mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            ret_q     <= ST_RUN;
            tmo_q     <= 8'd0;
            drain_q   <= '0;
            abort_q   <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            tmo_q     <= tmo_d;
            drain_q   <= drain_d;
            abort_q   <= abort_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        tmo_d       = tmo_q;
        drain_d     = drain_q;
        abort_d     = abort_q;
        mem_err_d   = mem_err_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exma_en     = 1'b1;
        mawb_bubble = 1'b0;
        halt_ack    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (memstall) begin
                    {pc_en, ifid_en, idex_en, exma_en} = 4'b0000;
                    mawb_bubble = 1'b1;
                    ret_d       = ST_RUN;
                    tmo_d       = 8'd1;
                    abort_d     = 1'b0;
                    state_d     = ST_MEM_WAIT;
                end else if (ex_pcsel) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (dbg_halt_req) begin
                    drain_d = DW'(DRAIN_CYCLES - 1);
                    state_d = ST_DRAIN;
                end
            end
            ST_MEM_WAIT: begin
                {pc_en, ifid_en, idex_en, exma_en} = 4'b0000;
                mawb_bubble = 1'b1;
                if (ma_mem_ready || abort_q) begin
                    abort_d = 1'b0;
                    state_d = ret_q;
                end else if (tmo_q == 8'(MEM_TIMEOUT)) begin
                    mem_err_d = 1'b1;
                    abort_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                pc_en      = ex_pcsel;
                ifid_flush = 1'b1;
                if (memstall) begin
                    {pc_en, ifid_en, idex_en, exma_en} = 4'b0000;
                    ifid_flush  = 1'b0;
                    mawb_bubble = 1'b1;
                    ret_d       = ST_DRAIN;
                    tmo_d       = 8'd1;
                    abort_d     = 1'b0;
                    state_d     = ST_MEM_WAIT;
                end else begin
                    // A load-use stall must hold the ID instruction, so IF/ID is not flushed over it.
                    if (ex_pcsel) begin
                        idex_flush = 1'b1;
                    end else if (lu) begin
                        ifid_en    = 1'b0;
                        ifid_flush = 1'b0;
                        idex_flush = 1'b1;
                    end
                    if (!dbg_halt_req) begin
                        state_d = ST_RUN;
                    end else if (!lu) begin
                        if (drain_q == '0) state_d = ST_HALTED;
                        else               drain_d = drain_q - DW'(1);
                    end
                end
            end
            ST_HALTED: begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                halt_ack   = 1'b1;
                if (!dbg_halt_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign mem_err    = mem_err_q;
    assign ctrl_state = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic             active;
    logic [CNT_W-1:0] perf_lu_q, perf_flush_q, perf_memwait_q;

    assign active = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !memstall;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lu_q      <= '0;
            perf_flush_q   <= '0;
            perf_memwait_q <= '0;
        end else begin
            if (active && !ex_pcsel && lu && (perf_lu_q != '1))
                perf_lu_q <= perf_lu_q + 1'b1;
            if (active && ex_pcsel && (perf_flush_q != '1))
                perf_flush_q <= perf_flush_q + 1'b1;
            if ((state_q == ST_MEM_WAIT) && (perf_memwait_q != '1))
                perf_memwait_q <= perf_memwait_q + 1'b1;
        end
    end

    assign perf_lu      = perf_lu_q;
    assign perf_flush   = perf_flush_q;
    assign perf_memwait = perf_memwait_q;
`else
    assign perf_lu      = '0;
    assign perf_flush   = '0;
    assign perf_memwait = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT shortened to 4).
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_regwen, ex_is_load, ex_pcsel;
    logic        ma_mem_req, ma_mem_ready, dbg_halt_req;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exma_en;
    logic        mawb_bubble, halt_ack, mem_err;
    logic [1:0]  ctrl_state;
    logic [31:0] perf_lu, perf_flush, perf_memwait;

    int passCount = 0;
    int checkCount = 0;

    // Strobe vectors: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exma_en, mawb_bubble}
    localparam logic [6:0] S_NORM   = 7'b1101010;
    localparam logic [6:0] S_LU     = 7'b0001110;
    localparam logic [6:0] S_FLUSH  = 7'b1111110;
    localparam logic [6:0] S_FREEZE = 7'b0000001;
    localparam logic [6:0] S_DRAIN  = 7'b0111010;

    pipeline_ctrl #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_rd        (ex_rd),
        .ex_regwen    (ex_regwen),
        .ex_is_load   (ex_is_load),
        .ex_pcsel     (ex_pcsel),
        .ma_mem_req   (ma_mem_req),
        .ma_mem_ready (ma_mem_ready),
        .dbg_halt_req (dbg_halt_req),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exma_en      (exma_en),
        .mawb_bubble  (mawb_bubble),
        .halt_ack     (halt_ack),
        .mem_err      (mem_err),
        .ctrl_state   (ctrl_state),
        .perf_lu      (perf_lu),
        .perf_flush   (perf_flush),
        .perf_memwait (perf_memwait)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic regwen, input logic isLoad, input logic pcsel,
                                 input logic memReq, input logic memReady, input logic dbg);
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rs1_used  = u1;
        id_rs2_used  = u2;
        ex_rd        = rd;
        ex_regwen    = regwen;
        ex_is_load   = isLoad;
        ex_pcsel     = pcsel;
        ma_mem_req   = memReq;
        ma_mem_ready = memReady;
        dbg_halt_req = dbg;
        #1;
    endtask

    task automatic idleStimulus(input logic pcsel, input logic memReq,
                                input logic memReady, input logic dbg);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, pcsel, memReq, memReady, dbg);
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] strobes,
                               input logic expHalt, input logic expErr, input logic [1:0] expState);
        logic [10:0] obs;
        logic [10:0] exp;
        obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exma_en, mawb_bubble,
               halt_ack, mem_err, ctrl_state};
        exp = {strobes, expHalt, expErr, expState};
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        idleStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_state", S_NORM, 1'b0, 1'b0, 2'd0);
        checkCount++;
        assert (perf_lu === 32'd0) passCount++;
        else $error("[TB] FAIL reset_perf_lu: observed %0d expected 0", perf_lu);
        reset = 1'b0;
        nextCycle();

        // Load-use on rs1, then the add proceeds behind the bubble.
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs1", S_LU, 1'b0, 1'b0, 2'd0);
        nextCycle();
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_release", S_NORM, 1'b0, 1'b0, 2'd0);
        nextCycle();
        applyStimulus(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2", S_LU, 1'b0, 1'b0, 2'd0);
        applyStimulus(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2_unused", S_NORM, 1'b0, 1'b0, 2'd0);
        applyStimulus(5'd0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rd_x0", S_NORM, 1'b0, 1'b0, 2'd0);
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_no_regwen", S_NORM, 1'b0, 1'b0, 2'd0);
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_not_load", S_NORM, 1'b0, 1'b0, 2'd0);

        // Branch flush beats load-use.
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pcsel_over_lu", S_FLUSH, 1'b0, 1'b0, 2'd0);
        idleStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pcsel_alone", S_FLUSH, 1'b0, 1'b0, 2'd0);
        nextCycle();

        // Memory wait: ready on the third MEM_WAIT cycle, branch held off by the freeze.
        idleStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("mem_enter", S_FREEZE, 1'b0, 1'b0, 2'd0);
        nextCycle();
        idleStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mem_wait1", S_FREEZE, 1'b0, 1'b0, 2'd1);
        nextCycle();
        checkOutput("mem_wait2", S_FREEZE, 1'b0, 1'b0, 2'd1);
        nextCycle();
        idleStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("mem_wait3_ready", S_FREEZE, 1'b0, 1'b0, 2'd1);
        nextCycle();
        idleStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mem_back_run", S_NORM, 1'b0, 1'b0, 2'd0);
        nextCycle();

        // Debug drain with a memory stall on the second drain step.
        idleStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("halt_req_run", S_NORM, 1'b0, 1'b0, 2'd0);
        nextCycle();
        checkOutput("drain_step1", S_DRAIN, 1'b0, 1'b0, 2'd2);
        nextCycle();
        idleStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("drain_step2_stall", S_FREEZE, 1'b0, 1'b0, 2'd2);
        nextCycle();
        idleStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("drain_memwait", S_FREEZE, 1'b0, 1'b0, 2'd1);
        nextCycle();
        idleStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("drain_resume%0d", i), S_DRAIN, 1'b0, 1'b0, 2'd2);
            nextCycle();
        end
        checkOutput("halted", S_DRAIN, 1'b1, 1'b0, 2'd3);
        nextCycle();
        idleStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("halted_req_drop", S_DRAIN, 1'b1, 1'b0, 2'd3);
        nextCycle();
        checkOutput("unhalt_run", S_NORM, 1'b0, 1'b0, 2'd0);
        nextCycle();

        // Drain abandoned when the request drops; branch inside drain.
        idleStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        idleStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("drain_pcsel", S_FLUSH, 1'b0, 1'b0, 2'd2);
        nextCycle();
        idleStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("drain_abort", S_DRAIN, 1'b0, 1'b0, 2'd2);
        nextCycle();
        checkOutput("drain_abort_run", S_NORM, 1'b0, 1'b0, 2'd0);
        nextCycle();

        // Timeout: 4 counted MEM_WAIT cycles, a 5th with mem_err set, then release.
        idleStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("tmo_enter", S_FREEZE, 1'b0, 1'b0, 2'd0);
        nextCycle();
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("tmo_wait%0d", i), S_FREEZE, 1'b0, 1'b0, 2'd1);
            nextCycle();
        end
        idleStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("tmo_abort", S_FREEZE, 1'b0, 1'b1, 2'd1);
        nextCycle();
        checkOutput("tmo_release", S_NORM, 1'b0, 1'b1, 2'd0);
        nextCycle();
        checkOutput("tmo_sticky", S_NORM, 1'b0, 1'b1, 2'd0);
        nextCycle();

        // Reset abandons an in-flight wait and clears mem_err.
        idleStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        reset = 1'b1;
        idleStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        reset = 1'b0;
        checkOutput("reset_from_memwait", S_NORM, 1'b0, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
